// File: rtl/elapsed_time_tracker_pkg.sv
// Shared types and helpers for the playback elapsed-time tracker: conversion
// FSM states, timing constants and the two-digit BCD split.
package elapsed_time_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    LOAD   = 2'd2
  } conv_state_t;

  localparam int SECS_PER_MIN        = 60;
  localparam int CLK_HZ_DEFAULT      = 3000;
  localparam int MAX_SECONDS_DEFAULT = 3599;
  localparam int DELTA_W_DEFAULT     = 9;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Only ever fed minutes or seconds, so the value is always below 60.
  function automatic bcd2_t bin2bcd_lt60(input logic [5:0] value);
    bcd2_t r;
    r.tens = 4'(value / 6'd10);
    r.ones = 4'(value % 6'd10);
    return r;
  endfunction

endpackage

// File: rtl/elapsed_time_tracker_if.sv
// Seek/time interface between the playback address generator (master) and the
// elapsed-time tracker (slave) that feeds the 7-segment display driver.
interface elapsed_time_tracker_if
  import elapsed_time_tracker_pkg::*;
#(
  parameter int DELTA_W = DELTA_W_DEFAULT
);
  logic                      count;
  logic                      seek_valid;
  logic signed [DELTA_W-1:0] seek_delta;
  logic [11:0]               total_s;
  logic [3:0]                min_tens;
  logic [3:0]                min_ones;
  logic [3:0]                sec_tens;
  logic [3:0]                sec_ones;
  logic                      busy;

  modport master (
    output count, seek_valid, seek_delta,
    input  total_s, min_tens, min_ones, sec_tens, sec_ones, busy
  );

  modport slave (
    input  count, seek_valid, seek_delta,
    output total_s, min_tens, min_ones, sec_tens, sec_ones, busy
  );
endinterface

// File: rtl/elapsed_time_tracker_div60_seq.sv
// Repeated-subtraction divide-by-60: one subtraction per cycle after i_start,
// o_done rises once the remainder drops below 60.
module div60_seq
  import elapsed_time_tracker_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [11:0] i_value,
  output logic        o_done,
  output logic [5:0]  o_quot,
  output logic [5:0]  o_rem
);

  logic [11:0] r_work;
  logic [5:0]  r_quot;
  logic        r_active;
  logic        w_ge60;

  assign w_ge60 = (r_work >= 12'(SECS_PER_MIN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_work   <= '0;
      r_quot   <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_work   <= i_value;
      r_quot   <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (w_ge60) begin
        r_work <= r_work - 12'(SECS_PER_MIN);
        r_quot <= r_quot + 6'd1;
      end else begin
        r_active <= 1'b0;
      end
    end
  end

  assign o_done = r_active & ~w_ge60;
  assign o_quot = r_quot;
  assign o_rem  = r_work[5:0];

endmodule

// File: rtl/elapsed_time_tracker.sv
// Elapsed playback time in seconds with saturating seek, plus a multi-cycle
// mm:ss BCD conversion whose four digits are always updated together.
//
//   state  | meaning
//   IDLE   | digits current; waiting for total_s to change
//   DIVIDE | div60_seq splitting the latched total into minutes/seconds
//   LOAD   | write all four digits; restart if a newer total arrived
module elapsed_time_tracker
  import elapsed_time_tracker_pkg::*;
#(
  parameter int CLK_HZ      = CLK_HZ_DEFAULT,
  parameter int MAX_SECONDS = MAX_SECONDS_DEFAULT,
  parameter int DELTA_W     = DELTA_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  elapsed_time_tracker_if.slave io
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic signed [13:0] MAX_S = 14'(MAX_SECONDS);

  logic [PW-1:0]      r_presc;
  logic [11:0]        r_total;
  logic [11:0]        r_total_d;
  logic               w_tick;
  logic signed [13:0] w_delta;
  logic signed [13:0] w_sum;
  logic               w_changed;

  assign w_tick    = io.count && (r_presc == PW'(CLK_HZ - 1));
  assign w_delta   = io.seek_valid ?
                     {{(14-DELTA_W){io.seek_delta[DELTA_W-1]}}, io.seek_delta} : '0;
  assign w_sum     = $signed({2'b00, r_total}) + $signed({13'd0, w_tick}) + w_delta;
  assign w_changed = (r_total != r_total_d);

  // Clamping to zero also restarts the second so playback resumes from a clean 00:00.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc   <= '0;
      r_total   <= '0;
      r_total_d <= '0;
    end else begin
      r_total_d <= r_total;
      if (w_sum[13]) begin
        r_total <= '0;
        r_presc <= '0;
      end else begin
        if (io.count) r_presc <= w_tick ? '0 : r_presc + 1'b1;
        r_total <= (w_sum > MAX_S) ? 12'(MAX_SECONDS) : w_sum[11:0];
      end
    end
  end

  conv_state_t r_state, w_state_nxt;
  logic        r_pending, w_pending_nxt;
  logic        w_start;
  logic        w_load;
  logic        w_div_done;
  logic [5:0]  w_quot;
  logic [5:0]  w_rem;

  div60_seq u_div60 (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_value (r_total),
    .o_done  (w_div_done),
    .o_quot  (w_quot),
    .o_rem   (w_rem)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // A change seen during LOAD itself counts as pending so it is not lost.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_start       = 1'b0;
    w_load        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_changed) begin
          w_start     = 1'b1;
          w_state_nxt = DIVIDE;
        end
      end
      DIVIDE: begin
        if (w_changed)  w_pending_nxt = 1'b1;
        if (w_div_done) w_state_nxt   = LOAD;
      end
      LOAD: begin
        w_load = 1'b1;
        if (r_pending || w_changed) begin
          w_pending_nxt = 1'b0;
          w_start       = 1'b1;
          w_state_nxt   = DIVIDE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  bcd2_t w_min_bcd, w_sec_bcd;
  logic [3:0] r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;

  assign w_min_bcd = bin2bcd_lt60(w_quot);
  assign w_sec_bcd = bin2bcd_lt60(w_rem);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_min_tens <= '0;
      r_min_ones <= '0;
      r_sec_tens <= '0;
      r_sec_ones <= '0;
    end else if (w_load) begin
      r_min_tens <= w_min_bcd.tens;
      r_min_ones <= w_min_bcd.ones;
      r_sec_tens <= w_sec_bcd.tens;
      r_sec_ones <= w_sec_bcd.ones;
    end
  end

  assign io.total_s  = r_total;
  assign io.min_tens = r_min_tens;
  assign io.min_ones = r_min_ones;
  assign io.sec_tens = r_sec_tens;
  assign io.sec_ones = r_sec_ones;
  assign io.busy     = (r_state != IDLE);

endmodule
